// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA scanout bursts take fixed priority,
// and the drawing engine and CPU reads share the remaining cycles round-robin.
module fb_mem_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int BURST_LEN = 16,
    parameter int RAM_LAT   = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_done,
    input  logic              draw_valid,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ready,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(BURST_LEN);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   base;
    logic                rr_cpu;
    logic [2:0]          issue_tag;   // {scan, cpu, last}
    logic [2:0]          tag_pipe [RAM_LAT];
    logic [2:0]          tag_out;
    logic [DATA_W-1:0]   scan_hold;
    logic [DATA_W-1:0]   cpu_hold;

    // Grants are combinational so the RAM access lands in the decision cycle;
    // gating with RESET_N keeps every output low while reset is held.
    always_comb begin
        next_state = state;
        scan_gnt   = 1'b0;
        draw_ready = 1'b0;
        cpu_ready  = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        issue_tag  = '0;
        if (RESET_N) begin
            case (state)
                IDLE: begin
                    if (scan_req) begin
                        scan_gnt   = 1'b1;
                        ram_en     = 1'b1;
                        ram_addr   = scan_addr;
                        issue_tag  = 3'b100;
                        next_state = SCAN;
                    end else if (draw_valid && (!cpu_valid || !rr_cpu)) begin
                        draw_ready = 1'b1;
                        ram_en     = 1'b1;
                        ram_we     = 1'b1;
                        ram_addr   = draw_addr;
                        ram_wdata  = draw_data;
                    end else if (cpu_valid) begin
                        cpu_ready  = 1'b1;
                        ram_en     = 1'b1;
                        ram_addr   = cpu_addr;
                        issue_tag  = 3'b010;
                    end
                end
                SCAN: begin
                    ram_en    = 1'b1;
                    ram_addr  = base + ADDR_W'(count);
                    issue_tag = 3'b100;
                    if (count == CNT_W'(BURST_LEN - 1)) begin
                        issue_tag[0] = 1'b1;
                        next_state   = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            count     <= '0;
            base      <= '0;
            rr_cpu    <= 1'b0;
            scan_hold <= '0;
            cpu_hold  <= '0;
            for (int unsigned i = 0; i < RAM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            state <= next_state;
            if (scan_gnt) begin
                base  <= scan_addr;
                count <= CNT_W'(1);
            end else if (state == SCAN) begin
                count <= count + CNT_W'(1);
            end
            if (draw_ready || cpu_ready) rr_cpu <= ~rr_cpu;
            tag_pipe[0] <= issue_tag;
            for (int unsigned i = 1; i < RAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (scan_rvalid) scan_hold <= ram_rdata;
            if (cpu_rvalid)  cpu_hold  <= ram_rdata;
        end
    end

    assign tag_out     = tag_pipe[RAM_LAT-1];
    assign scan_rvalid = tag_out[2];
    assign scan_done   = tag_out[2] & tag_out[0];
    assign cpu_rvalid  = tag_out[1];
    assign scan_rdata  = scan_rvalid ? ram_rdata : scan_hold;
    assign cpu_rdata   = cpu_rvalid ? ram_rdata : cpu_hold;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboarded bench for fb_mem_arbiter: stimulus queues expected grants, RAM
// accesses and read returns; a negedge monitor pops and compares them.
module tb_fb_mem_arbiter;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        scan_req;
    logic [18:0] scan_addr;
    logic        scan_gnt, scan_rvalid, scan_done;
    logic [23:0] scan_rdata;
    logic        draw_valid, draw_ready;
    logic [18:0] draw_addr;
    logic [23:0] draw_data;
    logic        cpu_valid, cpu_ready, cpu_rvalid;
    logic [18:0] cpu_addr;
    logic [23:0] cpu_rdata;
    logic        ram_en, ram_we;
    logic [18:0] ram_addr;
    logic [23:0] ram_wdata, ram_rdata;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [63:0] gnt_q[$];
    logic [63:0] ram_q[$];
    logic [63:0] scan_q[$];
    logic [63:0] cpu_q[$];

    fb_mem_arbiter #(.ADDR_W(19), .DATA_W(24), .BURST_LEN(16), .RAM_LAT(2)) dut (
        .CLOCK_50(clk), .RESET_N(RESET_N),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata), .scan_done(scan_done),
        .draw_valid(draw_valid), .draw_addr(draw_addr), .draw_data(draw_data),
        .draw_ready(draw_ready),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [23:0] pix(input logic [18:0] a);
        return {5'h15, a};
    endfunction

    // Two-cycle read-latency RAM whose contents are a fixed function of address.
    logic [23:0] rd_pipe [2];
    always @(posedge clk) begin
        rd_pipe[0] <= (ram_en && !ram_we) ? pix(ram_addr) : 24'h0;
        rd_pipe[1] <= rd_pipe[0];
    end
    assign ram_rdata = rd_pipe[1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int t, input logic [18:0] b);
        gnt_q.push_back(64'({16'(t), 3'b100}));
        for (int i = 0; i < 16; i++) begin
            ram_q.push_back({4'h0, 16'(t + i), 1'b0, b + 19'(i), 24'h0});
            scan_q.push_back({23'h0, 16'(t + 2 + i), i == 15, pix(b + 19'(i))});
        end
    endtask

    function automatic logic any_output();
        return |{scan_gnt, scan_rvalid, scan_rdata, scan_done, draw_ready, cpu_ready,
                 cpu_rvalid, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata};
    endfunction

    always @(negedge clk) begin
        if (RESET_N) begin
            if (scan_gnt || draw_ready || cpu_ready) begin
                if (gnt_q.size() == 0) chk("grant_unexpected", 64'({16'(cyc), scan_gnt, draw_ready, cpu_ready}), 64'h0);
                else chk("grant", 64'({16'(cyc), scan_gnt, draw_ready, cpu_ready}), gnt_q.pop_front());
            end
            if (ram_en) begin
                if (ram_q.size() == 0) chk("ram_unexpected", {4'h0, 16'(cyc), ram_we, ram_addr, ram_we ? ram_wdata : 24'h0}, 64'h0);
                else chk("ram_access", {4'h0, 16'(cyc), ram_we, ram_addr, ram_we ? ram_wdata : 24'h0}, ram_q.pop_front());
            end
            if (scan_rvalid) begin
                if (scan_q.size() == 0) chk("scan_unexpected", {23'h0, 16'(cyc), scan_done, scan_rdata}, 64'h0);
                else chk("scan_data", {23'h0, 16'(cyc), scan_done, scan_rdata}, scan_q.pop_front());
            end
            if (scan_done && !scan_rvalid) chk("done_without_valid", 64'h1, 64'h0);
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_unexpected", 64'({16'(cyc), cpu_rdata}), 64'h0);
                else chk("cpu_data", 64'({16'(cyc), cpu_rdata}), cpu_q.pop_front());
            end
        end
    end

    task automatic run_burst(input logic [18:0] b);
        int t;
        t = cyc;
        scan_req  = 1'b1;
        scan_addr = b;
        push_burst(t, b);
        step();
        scan_req = 1'b0;
        repeat (20) step();
    endtask

    initial begin
        int t;
        RESET_N = 1'b0; scan_req = 1'b1; scan_addr = 19'h1;
        draw_valid = 1'b0; draw_addr = '0; draw_data = '0;
        cpu_valid = 1'b0; cpu_addr = '0;
        step(); step();
        chk("reset_outputs", 64'(any_output()), 64'h0);
        scan_req = 1'b0;
        step();
        RESET_N = 1'b1;
        step();

        // Round-robin, draw first after reset
        t = cyc;
        draw_valid = 1'b1; draw_addr = 19'h11; draw_data = 24'h111111;
        cpu_valid  = 1'b1; cpu_addr  = 19'h22;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                gnt_q.push_back(64'({16'(t + k), 3'b010}));
                ram_q.push_back({4'h0, 16'(t + k), 1'b1, 19'h11, 24'h111111});
            end else begin
                gnt_q.push_back(64'({16'(t + k), 3'b001}));
                ram_q.push_back({4'h0, 16'(t + k), 1'b0, 19'h22, 24'h0});
                cpu_q.push_back(64'({16'(t + k + 2), pix(19'h22)}));
            end
        end
        repeat (4) step();
        draw_valid = 1'b0; cpu_valid = 1'b0;
        repeat (5) step();

        // Scan beats a simultaneous draw; draw lands right after the burst
        t = cyc;
        scan_req = 1'b1; scan_addr = 19'h200;
        draw_valid = 1'b1; draw_addr = 19'h5; draw_data = 24'hABCDEF;
        push_burst(t, 19'h200);
        gnt_q.push_back(64'({16'(t + 16), 3'b010}));
        ram_q.push_back({4'h0, 16'(t + 16), 1'b1, 19'h5, 24'hABCDEF});
        step();
        scan_req = 1'b0;
        repeat (16) step();
        draw_valid = 1'b0;
        repeat (20) step();

        run_burst(19'h00100);
        run_burst(19'h7FFF8);

        // Back-to-back bursts with a new base sampled at the second grant
        t = cyc;
        scan_req = 1'b1; scan_addr = 19'h300;
        push_burst(t, 19'h300);
        push_burst(t + 16, 19'h400);
        step();
        scan_addr = 19'h400;
        repeat (16) step();
        scan_req = 1'b0;
        repeat (20) step();

        // Reset mid-burst
        t = cyc;
        scan_req = 1'b1; scan_addr = 19'h500;
        gnt_q.push_back(64'({16'(t), 3'b100}));
        for (int i = 0; i < 5; i++) ram_q.push_back({4'h0, 16'(t + i), 1'b0, 19'h500 + 19'(i), 24'h0});
        for (int i = 0; i < 3; i++) scan_q.push_back({23'h0, 16'(t + 2 + i), 1'b0, pix(19'h500 + 19'(i))});
        step();
        scan_req = 1'b0;
        repeat (4) step();
        RESET_N = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 19'h33;
        #1;
        chk("midburst_reset_outputs", 64'(any_output()), 64'h0);
        repeat (3) begin
            step();
            chk("held_reset_outputs", 64'(any_output()), 64'h0);
        end
        cpu_valid = 1'b0;
        RESET_N = 1'b1;
        repeat (10) step();

        // A lone CPU read is granted at once, showing the FSM came back in IDLE
        t = cyc;
        cpu_valid = 1'b1; cpu_addr = 19'h44;
        gnt_q.push_back(64'({16'(t), 3'b001}));
        ram_q.push_back({4'h0, 16'(t), 1'b0, 19'h44, 24'h0});
        cpu_q.push_back(64'({16'(t + 2), pix(19'h44)}));
        step();
        cpu_valid = 1'b0;
        repeat (5) step();

        chk("gnt_q_drained",  64'(gnt_q.size()),  64'h0);
        chk("ram_q_drained",  64'(ram_q.size()),  64'h0);
        chk("scan_q_drained", 64'(scan_q.size()), 64'h0);
        chk("cpu_q_drained",  64'(cpu_q.size()),  64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Arbitrates a single-port synchronous framebuffer RAM between three requesters:
  - the VGA scanout line prefetcher (burst reads, real-time, highest priority);
  - the drawing engine (single-pixel writes);
  - a CPU/debug read port.
- Sits between the `vga` timing block and the framebuffer RAM, all on CLOCK_50.

Parameters:
- ADDR_W, 19: pixel address width (covers 640x480).
- DATA_W, 24: pixel width (8b R, G, B).
- BURST_LEN, 16: reads per scanout burst; power of two, 2..64.
- RAM_LAT, 2: RAM read latency in cycles (address to ram_rdata valid); 1..4.

Ports:
- CLOCK_50  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- scan_req  in  1  scanout burst request; level, held until scan_gnt
- scan_addr  in  ADDR_W  burst base address, sampled in the grant cycle
- scan_gnt  out  1  1-cycle pulse: burst accepted
- scan_rvalid  out  1  scan_rdata valid
- scan_rdata  out  DATA_W  burst read data, in address order
- scan_done  out  1  pulse coincident with last scan_rvalid of a burst
- draw_valid  in  1  write request
- draw_addr  in  ADDR_W  write address
- draw_data  in  DATA_W  write data
- draw_ready  out  1  write accepted when draw_valid&draw_ready
- cpu_valid  in  1  read request
- cpu_addr  in  ADDR_W  read address
- cpu_ready  out  1  read accepted when cpu_valid&cpu_ready
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  read data
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, RAM_LAT cycles after address

Behaviour:
- Reset (RESET_N low, asynchronous):
  - all outputs 0, FSM to IDLE;
  - burst counter, return pipeline and round-robin pointer cleared;
  - reset mid-burst abandons the burst: no further scan_rvalid, scan_done or cpu_rvalid.
- FSM states: IDLE, SCAN.
- IDLE, arbitration each cycle, fixed priority scan > {draw, cpu}:
  - scan_req=1: scan_gnt=1; latch scan_addr; issue ram_addr=scan_addr, ram_en=1, ram_we=0 this cycle; go to SCAN with count=1.
  - Else if draw_valid and/or cpu_valid: grant one per cycle.
    - Only one requesting: grant it.
    - Both requesting: round-robin; pointer starts at draw after reset and toggles after each draw/cpu grant.
  - draw grant: draw_ready=1; ram_en=1, ram_we=1, ram_addr=draw_addr, ram_wdata=draw_data the same cycle.
  - cpu grant: cpu_ready=1; ram_en=1, ram_we=0, ram_addr=cpu_addr.
  - draw_ready and cpu_ready are combinational from the cycle's decision; both are 0 whenever scan wins or the FSM is in SCAN.
- SCAN:
  - each cycle issue ram_addr = base+count (mod 2^ADDR_W), ram_en=1, ram_we=0, count++;
  - after issuing address BURST_LEN-1, return to IDLE;
  - a burst occupies exactly BURST_LEN consecutive RAM cycles; draw/cpu are never granted inside it.
- Return pipeline:
  - RAM_LAT-deep shift register of tags {scan, cpu, last}, loaded in every read-issue cycle;
  - at the output stage, tag scan gives scan_rvalid=1 with scan_rdata=ram_rdata; scan_done=1 when last is also set;
  - tag cpu gives cpu_rvalid=1 with cpu_rdata=ram_rdata;
  - rdata outputs hold their last value when valid is 0.
- Back-to-back:
  - new grants do not wait for pipeline drain; a scan_req still high on return to IDLE is granted in that cycle;
  - scan data is gap-free across consecutive bursts.
- Latency:
  - scan: first data at grant+RAM_LAT, last at grant+BURST_LEN-1+RAM_LAT;
  - cpu: data at accept+RAM_LAT;
  - draw write: occurs in the accept cycle.
- Worst-case scan wait from scan_req rising: 0 cycles (scan is checked before draw/cpu in IDLE) plus any remaining cycles of a burst in progress.
- Address arithmetic wraps modulo 2^ADDR_W; no bounds checking.
- draw/cpu inputs are sampled only in their accept cycle; requesters must hold them stable while valid=1 and ready=0.

Test Plan:
- Single burst, defaults:
  - stimulus: scan_req with scan_addr=0x00100 at cycle T;
  - response: scan_gnt at T; ram_addr 0x100..0x10F on T..T+15; scan_rvalid T+2..T+17 with data in order; scan_done only at T+17.
- Wrap:
  - stimulus: scan_addr=0x7FFF8;
  - response: ram_addr 0x7FFF8..0x7FFFF, then 0x00000..0x00007; scan_rdata follows the same order.
- Priority:
  - stimulus: scan_req and draw_valid (addr 0x5, data 0xABCDEF) both rise at T;
  - response: scan granted at T; draw_ready=0 T..T+15; write to 0x5 with ram_we=1 at T+16.
- Round-robin:
  - stimulus: draw_valid and cpu_valid held high, no scan;
  - response: grants alternate draw, cpu, draw, cpu starting at draw after reset; each cpu_rvalid 2 cycles after its cpu_ready.
- Back-to-back:
  - stimulus: scan_req held high for two bursts;
  - response: second scan_gnt at T+16; scan_rvalid continuous T+2..T+33; scan_done at T+17 and T+33.
- Reset mid-burst:
  - stimulus: RESET_N low at T+5 for 3 cycles, then high with no requests;
  - response: all outputs 0 immediately while reset is low; no scan_rvalid or scan_done afterwards; FSM in IDLE.
